// File: rtl/dmux_router_if.sv
// Handshake bundle for dmux_router: one upstream stream fanned out to four
// downstream channels, with channel k data packed on out_data[k*W +: W].
interface dmux_router_if #(
    parameter int W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dmux_router.sv
// 1-to-4 demultiplexing router with a one-entry holding buffer per channel.
// Optional per-channel saturating delivery counters when DMUX_CNT_EN is defined.
module dmux_router #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmux_router_if.slave  bus
`ifdef DMUX_CNT_EN
    ,
    input  logic          cnt_clr,
    output logic [31:0]   cnt
`endif
);

    logic [3:0]     ch_valid;
    logic [4*W-1:0] ch_data;
    logic           in_xfer;

    // Acceptance depends only on the selected channel, so a stalled channel
    // never blocks traffic bound elsewhere.
    assign bus.in_ready  = ~ch_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign in_xfer       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = ch_valid;
    assign bus.out_data  = ch_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic         valid_reg;
            logic         valid_next;
            logic [W-1:0] data_reg;
            logic [W-1:0] data_next;
            logic         load;
            logic         drain;

            assign load  = in_xfer && (bus.in_sel == 2'(gi));
            assign drain = valid_reg & bus.out_ready[gi];

            // A load wins over a drain so a full channel can be refilled
            // in the same cycle it delivers, without a bubble.
            always_comb begin
                valid_next = valid_reg;
                data_next  = data_reg;
                if (load) begin
                    valid_next = 1'b1;
                    data_next  = bus.in_data;
                end else if (drain) begin
                    valid_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= valid_next;
                    data_reg  <= data_next;
                end
            end

            assign ch_valid[gi]          = valid_reg;
            assign ch_data[gi*W +: W]    = data_reg;

`ifdef DMUX_CNT_EN
            logic [7:0] cnt_reg;
            logic [7:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_clr) begin
                    cnt_next = 8'd0;
                end else if (drain && (cnt_reg != 8'hFF)) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 8'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt[gi*8 +: 8] = cnt_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dmux_router.sv
// Directed self-checking bench for dmux_router; counter checks are compiled
// only when DMUX_CNT_EN is defined.
module tb_dmux_router;

    localparam int W = 8;

    logic clk;
    logic rst;
`ifdef DMUX_CNT_EN
    logic        cnt_clr;
    logic [31:0] cnt;
`endif

    int total;
    int bad;

    dmux_router_if #(.W(W)) bus ();

    dmux_router #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef DMUX_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt     (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
        step();
        step();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_valid got=%b want=%b", bus.out_valid, 4'b0000);
        end
        total++;
        if (bus.out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=%h", bus.out_data, 32'h0);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        rst = 1'b0;
        step();
        $display("reset: out_valid=%b out_data=%h in_ready=%b", bus.out_valid, bus.out_data, bus.in_ready);
    endtask

    task automatic test_route();
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'hA5;
        bus.out_ready = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL route_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'b0100) begin
            bad++;
            $display("FAIL route_valid got=%b want=%b", bus.out_valid, 4'b0100);
        end
        total++;
        if (bus.out_data[23:16] !== 8'hA5) begin
            bad++;
            $display("FAIL route_data got=%h want=%h", bus.out_data[23:16], 8'hA5);
        end
        step();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL route_drain got=%b want=%b", bus.out_valid, 4'b0000);
        end
        total++;
        if (bus.out_data[23:16] !== 8'hA5) begin
            bad++;
            $display("FAIL route_hold_empty got=%h want=%h", bus.out_data[23:16], 8'hA5);
        end
        $display("route: ch2 word A5 delivered, out_valid=%b", bus.out_valid);
    endtask

    task automatic test_stall();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h11;
        step();
        bus.in_data = 8'h99;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_in_ready got=%b want=0", bus.in_ready);
        end
        step();
        total++;
        if (bus.out_data[15:8] !== 8'h11) begin
            bad++;
            $display("FAIL stall_hold got=%h want=%h", bus.out_data[15:8], 8'h11);
        end
        bus.in_sel  = 2'd3;
        bus.in_data = 8'h22;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_other_ready got=%b want=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'b1010) begin
            bad++;
            $display("FAIL stall_valid got=%b want=%b", bus.out_valid, 4'b1010);
        end
        total++;
        if (bus.out_data[31:24] !== 8'h22 || bus.out_data[15:8] !== 8'h11) begin
            bad++;
            $display("FAIL stall_data got=%h want=22xx11xx", bus.out_data);
        end
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        $display("stall: ch1 held 11, ch3 got 22, drained out_valid=%b", bus.out_valid);
    endtask

    task automatic test_replace();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h33;
        step();
        bus.out_ready = 4'b0001;
        bus.in_data   = 8'h44;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL replace_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        total++;
        if (bus.out_valid !== 4'b0001) begin
            bad++;
            $display("FAIL replace_valid got=%b want=%b", bus.out_valid, 4'b0001);
        end
        total++;
        if (bus.out_data[7:0] !== 8'h44) begin
            bad++;
            $display("FAIL replace_data got=%h want=%h", bus.out_data[7:0], 8'h44);
        end
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        $display("replace: ch0 33 -> 44 with no bubble");
    endtask

    task automatic test_drain_all();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel  = 2'(i);
            bus.in_data = 8'(8'h10 + i);
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'b1111) begin
            bad++;
            $display("FAIL drain_full got=%b want=%b", bus.out_valid, 4'b1111);
        end
        total++;
        if (bus.out_data !== 32'h13121110) begin
            bad++;
            $display("FAIL drain_data got=%h want=%h", bus.out_data, 32'h13121110);
        end
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        #1;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL drain_empty got=%b want=%b", bus.out_valid, 4'b0000);
        end
        $display("drain_all: four words delivered in one cycle");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h5A;
        step();
        bus.in_sel  = 2'd2;
        bus.in_data = 8'h6B;
        step();
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'hFF;
        bus.out_ready = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_valid got=%b want=%b", bus.out_valid, 4'b0000);
        end
        total++;
        if (bus.out_data !== 32'h0) begin
            bad++;
            $display("FAIL midrst_data got=%h want=%h", bus.out_data, 32'h0);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready);
        end
        $display("reset_mid: held words discarded, out_valid=%b", bus.out_valid);
    endtask

`ifdef DMUX_CNT_EN
    task automatic test_counters();
        total++;
        if (cnt !== 32'h0) begin
            bad++;
            $display("FAIL cnt_reset got=%h want=%h", cnt, 32'h0);
        end
        bus.out_ready = 4'b1000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 8'h77;
        // First edge loads only; each further edge delivers one word.
        for (int i = 0; i < 11; i++) step();
        total++;
        if (cnt !== 32'h0A000000) begin
            bad++;
            $display("FAIL cnt_ten got=%h want=%h", cnt, 32'h0A000000);
        end
        for (int i = 0; i < 290; i++) step();
        total++;
        if (cnt !== 32'hFF000000) begin
            bad++;
            $display("FAIL cnt_saturate got=%h want=%h", cnt, 32'hFF000000);
        end
        cnt_clr      = 1'b1;
        bus.in_valid = 1'b0;
        step();
        cnt_clr = 1'b0;
        #1;
        total++;
        if (cnt !== 32'h0) begin
            bad++;
            $display("FAIL cnt_clear got=%h want=%h", cnt, 32'h0);
        end
        bus.out_ready = 4'b0000;
        $display("counters: ch3 saturated at 255 then cleared");
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef DMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        test_reset();
        test_route();
        test_stall();
        test_replace();
        test_drain_all();
        test_reset_mid();
`ifdef DMUX_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmux_router.md
DMUX_ROUTER -- requirements
Module: dmux_router

Interface
REQ-001 SHALL provide parameter: W, default 8, data width in bits.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: in_valid  input  1  upstream word present.
REQ-005 SHALL provide port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-006 SHALL provide port: in_data  input  W  upstream word.
REQ-007 SHALL provide port: in_sel  input  2  destination channel index 0..3.
REQ-008 SHALL provide port: out_valid  output  4  per-channel word held, bit k = channel k.
REQ-009 SHALL provide port: out_ready  input  4  per-channel downstream accept, bit k = channel k.
REQ-010 SHALL provide port: out_data  output  4*W  channel k data on bits [k*W +: W].
REQ-011 SHALL provide port: cnt_clr  input  1  clear all delivery counters (present only with DMUX_CNT_EN).
REQ-012 SHALL provide port: cnt  output  32  channel k saturating 8-bit delivery count on bits [k*8 +: 8] (present only with DMUX_CNT_EN).

Function
REQ-013 SHALL route each accepted input word to exactly one channel, selected by in_sel sampled in the same cycle: 00->0, 01->1, 10->2, 11->3.
REQ-014 SHALL hold one word per channel in a dedicated holding register plus valid flag (four independent one-entry buffers).
REQ-015 SHALL drive in_ready = ~out_valid[in_sel] | out_ready[in_sel], combinationally; no dependence on in_valid.
REQ-016 SHALL define an input transfer as in_valid & in_ready on a rising edge; on transfer, load in_data into channel in_sel and set out_valid[in_sel] next cycle (latency 1 cycle).
REQ-017 SHALL define an output transfer on channel k as out_valid[k] & out_ready[k]; on transfer without a simultaneous load to k, clear out_valid[k].
REQ-018 SHALL, when channel k is full, out_ready[k]=1 and an input transfer targets k in the same cycle, replace the data and keep out_valid[k]=1 (no bubble, no loss).
REQ-019 SHALL keep out_valid[k] and out_data channel k stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 SHALL NOT let a full, stalled channel block transfers to other channels; in_ready reflects only the selected channel.
REQ-021 SHALL leave out_data for a channel unchanged when that channel is empty and not loaded.
REQ-022 SHALL allow independent, simultaneous output transfers on all four channels in one cycle.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, clear out_valid to 4'b0000, out_data to all zeros, and cnt (if present) to zero.
REQ-024 SHALL, while rst=1, discard any input transfer and ignore out_ready; words held when reset asserts mid-operation are lost.
REQ-025 SHALL drive in_ready=1 during and after reset, as all channels are then empty.

Configuration
REQ-026 SHALL compile delivery counters only when macro DMUX_CNT_EN is defined.
REQ-027 SHALL, with DMUX_CNT_EN, increment channel k counter by 1 per output transfer on k, saturating at 255, and zero all counters on cnt_clr=1 (cnt_clr has priority over increment).
REQ-028 SHALL, without DMUX_CNT_EN, omit the cnt_clr and cnt ports and all counter logic; routing behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then in_valid=1, in_sel=2, in_data=8'hA5, out_ready=4'b1111 -> next cycle out_valid=4'b0100, channel 2 data=8'hA5, then out_valid=0.
REQ-030 SHALL cover: out_ready=4'b0000, write 8'h11 to ch1 -> ch1 full; second write to ch1 -> in_ready=0, data held 8'h11; write 8'h22 to ch3 -> accepted, out_valid=4'b1010.
REQ-031 SHALL cover: ch0 full with 8'h33, out_ready[0]=1, in_sel=0, in_data=8'h44 same cycle -> in_ready=1, next cycle out_valid[0]=1, data 8'h44.
REQ-032 SHALL cover: all four channels full, out_ready=4'b1111 for one cycle with in_valid=0 -> next cycle out_valid=4'b0000.
REQ-033 SHALL cover: two channels loaded, rst pulsed one cycle -> out_valid=0, out_data=0, in_ready=1.
REQ-034 SHALL cover, with DMUX_CNT_EN: 300 deliveries to ch3 -> cnt[31:24]=255; cnt_clr coincident with a delivery -> 0.
